phase_to_amplitude: RTL and testbench
=====================================

Name: phase_to_amplitude

Overview:
Downstream stage of the 10-bit phase accumulator in the DDS chain. Converts each 10-bit phase word into an 8-bit sine amplitude for the DAC interface. Stores only a quarter-wave magnitude table and uses quadrant symmetry. Implemented as a 3-stage pipeline with a valid flag and a global clock enable.

Parameters:
PHASE_W, 10, phase input width; 2 MSBs select the quadrant, 8 LSBs index the table.
AMP_W, 8, output amplitude width.
OFFSET_BINARY, 0, output format: 0 = two's complement, 1 = offset binary (two's complement value + 128) for a unipolar DAC.

Ports:
clock  input  1  system clock, 1 MHz nominal, all logic on the rising edge.
reset  input  1  asynchronous, active-low reset.
ce  input  1  pipeline clock enable; 0 freezes every pipeline register.
phase  input  10  phase word from the accumulator.
phase_valid  input  1  qualifies phase in the current cycle.
amplitude  output  8  sine sample, format set by OFFSET_BINARY.
amp_valid  output  1  qualifies amplitude.

Behaviour:
- Reset (reset=0, asynchronous assert; deassert is sampled on clock): all valid bits clear; amplitude = 8'h00 (OFFSET_BINARY=0) or 8'h80 (OFFSET_BINARY=1); all internal registers clear.
- Table: M(i) = round(127*sin(pi*(2i+1)/1024)), i = 0..255, unsigned 7-bit, range 0..127. Checkpoints: M(0)=0, M(16)=13, M(128)=90, M(255)=127.
- Quadrant q = phase[9:8], index k = phase[7:0]:
  - q0: +M(k)
  - q1: +M(255-k)
  - q2: -M(k)
  - q3: -M(255-k)
- Mirror index 255-k is the bitwise NOT of k.
- Signed result range is -127..+127; -128 is never produced.
- Pipeline, when ce=1:
  - S1 registers the mirrored index, the negate flag (q[1]) and phase_valid.
  - S2 registers the table output, negate flag and valid.
  - S3 registers the final amplitude (negation, plus 128 if offset binary) and amp_valid.
- Latency is exactly 3 enabled clock edges from phase/phase_valid to amplitude/amp_valid. Throughput is one sample per enabled cycle.
- ce=0: all stages, including amplitude and amp_valid, hold their values. Inputs presented while ce=0 are ignored.
- phase_valid=0: the data path still advances. The valid bit propagates as 0 and amplitude keeps updating, but it is don't-care when amp_valid=0.
- No backpressure: a consumer must accept every sample flagged by amp_valid.
- Reset asserted mid-stream: in-flight samples are discarded. The first valid output after reset is the first phase_valid sample presented after deassertion, 3 enabled edges later.
- Phase wrap (1023 -> 0) needs no special handling. Output is continuous: phase 1023 gives -M(0) = 0, and phase 0 gives 0.
- Zero is emitted as 8'h00 (or 8'h80) in all quadrants. There is no negative-zero encoding.

Decomposition:
- Shared package dds_pkg holds:
  - PHASE_W, AMP_W and QUARTER_DEPTH=256 constants
  - the amplitude typedef
  - a constant function that computes the M(i) table, shared by the RTL and the bench reference model
- One sub-module, quarter_sine_rom: 256x7 synchronous-read ROM with address, enable and data ports. It forms pipeline stage S2.

Test Plan:
- Reset check: hold reset=0, then release with ce=1 and phase_valid=0 -> amp_valid=0 and amplitude=8'h00 (8'h80 with OFFSET_BINARY=1) until the first valid sample.
- Quadrant checkpoints: phase 0, 256, 512, 768, 128, 16, each with phase_valid=1 -> 3 cycles later amplitude = 0, +127, 0, -127, +90, +13 (two's complement).
- Accumulator stream: phase stepping by 16 from 0 and wrapping at 1024 -> output repeats every 64 samples, is antisymmetric about phase 512, and matches the package model bit-exact.
- ce gating: drop ce for 5 cycles mid-stream -> outputs frozen, no samples lost or duplicated, latency still 3 enabled edges.
- Reset mid-operation: assert reset with 3 samples in flight -> amp_valid drops immediately (asynchronous), and no stale sample appears after release.
- Offset binary build: phase 768 and 256 -> 8'h01 and 8'hFF; full sweep never produces 8'h00.

Source files
------------

// File: rtl/dds_pkg.sv
// Shared definitions for the DDS phase-to-amplitude stage: widths, types and
// the quarter-wave sine magnitude table generator.
package dds_pkg;

    localparam int PHASE_W       = 10;
    localparam int AMP_W         = 8;
    localparam int QUARTER_DEPTH = 256;
    localparam int INDEX_W       = 8;
    localparam int MAG_W         = 7;

    typedef logic [AMP_W-1:0]   amplitude_t;
    typedef logic [INDEX_W-1:0] index_t;
    typedef logic [MAG_W-1:0]   magnitude_t;
    typedef logic [QUARTER_DEPTH-1:0][MAG_W-1:0] quarter_table_t;

    // Fixed-point format used while building the table: Q(64-FRAC_W).FRAC_W.
    // Integer arithmetic keeps the generator usable in any elaboration context.
    localparam int     FRAC_W = 28;
    localparam longint ONE    = 64'sd1 <<< FRAC_W;
    // round(pi * 2^28)
    localparam longint PI_FIX = 64'sd843314857;

    // M(i) = round(127 * sin(pi * (2i+1) / 1024)), i = 0..255.
    // The sample points sit half a step off the axis so the quarter wave
    // mirrors cleanly with a bitwise-NOT index and never repeats a sample.
    function automatic magnitude_t sine_magnitude(input int i);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint scaled;
        x    = (PI_FIX * longint'(2 * i + 1) + 64'sd512) / 64'sd1024;
        x2   = (x * x) >>> FRAC_W;
        term = x;
        sum  = x;
        // Taylor series for sin(x), x <= pi/2; ten terms is far below one LSB.
        for (int n = 1; n <= 10; n++) begin
            term = -(((term * x2) >>> FRAC_W) / longint'((2 * n) * (2 * n + 1)));
            sum  = sum + term;
        end
        scaled = (64'sd127 * sum + (ONE >>> 1)) >>> FRAC_W;
        if (scaled > 64'sd127) scaled = 64'sd127;
        if (scaled < 64'sd0)   scaled = 64'sd0;
        return magnitude_t'(scaled);
    endfunction

    // Whole quarter-wave table as one packed constant.
    function automatic quarter_table_t quarter_table();
        quarter_table_t t;
        t = '0;
        for (int i = 0; i < QUARTER_DEPTH; i++) begin
            t[i] = sine_magnitude(i);
        end
        return t;
    endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// 256 x 7 quarter-wave sine magnitude ROM with a registered, enabled read port.
// Forms the second pipeline stage of phase_to_amplitude.
module quarter_sine_rom
    import dds_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       en,
    input  index_t     addr,
    output magnitude_t data
);

    localparam quarter_table_t TABLE = quarter_table();

    // Synchronous read: the output register is the pipeline register.
    // NOTE: the table contents are constants and need no reset; only the read
    // register is cleared so the pipeline starts from a known zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data <= '0;
        end else if (en) begin
            data <= TABLE[addr];
        end
    end

endmodule

// File: rtl/phase_to_amplitude.sv
// DDS phase-to-amplitude converter. Maps a 10-bit phase word to an 8-bit sine
// sample using a quarter-wave table and quadrant symmetry:
//   q0: +M(k)   q1: +M(~k)   q2: -M(k)   q3: -M(~k)
// Three-stage pipeline (index/negate, table read, sign/format) with a valid
// flag and a global clock enable that freezes every stage when low.
module phase_to_amplitude #(
    parameter int PHASE_W       = 10,
    parameter int AMP_W         = 8,
    parameter bit OFFSET_BINARY = 1'b0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ce,
    input  logic [PHASE_W-1:0] phase,
    input  logic               phase_valid,
    output logic [AMP_W-1:0]   amplitude,
    output logic               amp_valid
);

    // Idle output level: mid-scale in either format.
    localparam logic [AMP_W-1:0] RESET_AMP =
        OFFSET_BINARY ? {1'b1, {(AMP_W-1){1'b0}}} : '0;

    // Phase decomposition: q[0] mirrors the index, q[1] negates the result.
    logic                  mirror;
    logic                  negate;
    dds_pkg::index_t       table_index;

    assign mirror      = phase[PHASE_W-2];
    assign negate      = phase[PHASE_W-1];
    assign table_index = phase[PHASE_W-3:0];

    // Stage 1 registers
    dds_pkg::index_t       s1_index;
    logic                  s1_negate;
    logic                  s1_valid;

    // Stage 2 registers (table data lives inside the ROM)
    dds_pkg::magnitude_t   s2_magnitude;
    logic                  s2_negate;
    logic                  s2_valid;

    // Stage 3 combinational input
    logic [AMP_W-1:0]      amp_next;

    // S1: mirror the index (255-k == ~k) and capture the sign and valid.
    // NOTE: every clocked assignment is non-blocking so all stages sample the
    // previous cycle's values and shift together on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_index  <= '0;
            s1_negate <= 1'b0;
            s1_valid  <= 1'b0;
        end else if (ce) begin
            s1_index  <= mirror ? ~table_index : table_index;
            s1_negate <= negate;
            s1_valid  <= phase_valid;
        end
    end

    // S2: table lookup, registered inside the ROM under the same enable.
    quarter_sine_rom u_rom (
        .clock (clock),
        .reset (reset),
        .en    (ce),
        .addr  (s1_index),
        .data  (s2_magnitude)
    );

    // S2: carry sign and valid alongside the table read.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s2_negate <= 1'b0;
            s2_valid  <= 1'b0;
        end else if (ce) begin
            s2_negate <= s1_negate;
            s2_valid  <= s1_valid;
        end
    end

    // S3 datapath: apply the sign, then optionally shift to offset binary.
    // Magnitude tops out at 127, so the negated value stays in -127..+127
    // and negating zero gives zero (no negative-zero code). Adding 128 modulo
    // 256 is the same as inverting the MSB.
    // NOTE: amp_next is assigned at the top of the block so every path drives
    // it and no latch is inferred.
    always_comb begin
        amp_next = AMP_W'(s2_magnitude);
        if (s2_negate) begin
            amp_next = -amp_next;
        end
        if (OFFSET_BINARY) begin
            amp_next[AMP_W-1] = ~amp_next[AMP_W-1];
        end
    end

    // S3: register the final sample and its valid flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            amplitude <= RESET_AMP;
            amp_valid <= 1'b0;
        end else if (ce) begin
            amplitude <= amp_next;
            amp_valid <= s2_valid;
        end
    end

endmodule

// File: tb/tb_phase_to_amplitude.sv
// Self-checking bench for phase_to_amplitude. Two instances (two's complement
// and offset binary) share one stimulus; a scoreboard queue per instance holds
// the expected samples in order.
module tb_phase_to_amplitude;
    import dds_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        ce;
    logic [9:0]  phase;
    logic        phase_valid;

    amplitude_t  amplitude_tc;
    logic        amp_valid_tc;
    amplitude_t  amplitude_ob;
    logic        amp_valid_ob;

    int          total = 0;
    int          bad   = 0;

    amplitude_t  exp_tc_q[$];
    amplitude_t  exp_ob_q[$];
    logic [2:0]  valid_pipe;
    amplitude_t  cur_tc;
    amplitude_t  cur_ob;

    always #5 clock = ~clock;

    phase_to_amplitude #(
        .PHASE_W       (10),
        .AMP_W         (8),
        .OFFSET_BINARY (1'b0)
    ) dut_tc (
        .clock       (clock),
        .reset       (reset),
        .ce          (ce),
        .phase       (phase),
        .phase_valid (phase_valid),
        .amplitude   (amplitude_tc),
        .amp_valid   (amp_valid_tc)
    );

    phase_to_amplitude #(
        .PHASE_W       (10),
        .AMP_W         (8),
        .OFFSET_BINARY (1'b1)
    ) dut_ob (
        .clock       (clock),
        .reset       (reset),
        .ce          (ce),
        .phase       (phase),
        .phase_valid (phase_valid),
        .amplitude   (amplitude_ob),
        .amp_valid   (amp_valid_ob)
    );

    // Reference model: quadrant symmetry over the package table.
    function automatic amplitude_t model_amp(input logic [9:0] ph, input bit offset);
        index_t     k;
        amplitude_t v;
        k = ph[7:0];
        if (ph[8]) k = 8'd255 - k;
        v = amplitude_t'(sine_magnitude(int'(k)));
        if (ph[9]) v = 8'd0 - v;
        if (offset) v = v + 8'h80;
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_nonzero(input string tag, input amplitude_t obs);
        total++;
        assert (obs !== 8'h00) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=nonzero", tag, obs);
        end
    endtask

    // One clock with explicit expected values for a valid sample.
    task automatic step_exp(input logic ce_v, input logic valid_v, input logic [9:0] ph,
                            input amplitude_t e_tc, input amplitude_t e_ob);
        ce          = ce_v;
        phase_valid = valid_v;
        phase       = ph;
        @(posedge clock);
        #1;
        if (ce_v) begin
            valid_pipe = {valid_pipe[1:0], valid_v};
            if (valid_v) begin
                exp_tc_q.push_back(e_tc);
                exp_ob_q.push_back(e_ob);
            end
        end
        check("valid_tc", 32'(amp_valid_tc), 32'(valid_pipe[2]));
        check("valid_ob", 32'(amp_valid_ob), 32'(valid_pipe[2]));
        if (valid_pipe[2]) begin
            if (ce_v) begin
                if (exp_tc_q.size() == 0 || exp_ob_q.size() == 0) begin
                    total++;
                    bad++;
                    $error("FAIL scoreboard_underflow: observed=empty expected=sample");
                end else begin
                    cur_tc = exp_tc_q.pop_front();
                    cur_ob = exp_ob_q.pop_front();
                end
            end
            check("amp_tc", 32'(amplitude_tc), 32'(cur_tc));
            check("amp_ob", 32'(amplitude_ob), 32'(cur_ob));
            check_nonzero("ob_nonzero", amplitude_ob);
        end
    endtask

    // One clock with model-derived expectations.
    task automatic step(input logic ce_v, input logic valid_v, input logic [9:0] ph);
        step_exp(ce_v, valid_v, ph, model_amp(ph, 1'b0), model_amp(ph, 1'b1));
    endtask

    initial begin
        reset       = 1'b0;
        ce          = 1'b1;
        phase_valid = 1'b0;
        phase       = '0;
        valid_pipe  = '0;
        cur_tc      = '0;
        cur_ob      = '0;

        // Reset state
        #12;
        check("rst_valid_tc", 32'(amp_valid_tc), 32'd0);
        check("rst_valid_ob", 32'(amp_valid_ob), 32'd0);
        check("rst_amp_tc",   32'(amplitude_tc), 32'h00);
        check("rst_amp_ob",   32'(amplitude_ob), 32'h80);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Idle after release: no valid, mid-scale output.
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 10'd0);
            check("idle_amp_tc", 32'(amplitude_tc), 32'h00);
            check("idle_amp_ob", 32'(amplitude_ob), 32'h80);
        end

        // Quadrant checkpoints with hand-derived values.
        step_exp(1'b1, 1'b1, 10'd0,   8'h00, 8'h80);
        step_exp(1'b1, 1'b1, 10'd256, 8'h7F, 8'hFF);
        step_exp(1'b1, 1'b1, 10'd512, 8'h00, 8'h80);
        step_exp(1'b1, 1'b1, 10'd768, 8'h81, 8'h01);
        step_exp(1'b1, 1'b1, 10'd128, 8'h5A, 8'hDA);
        step_exp(1'b1, 1'b1, 10'd16,  8'h0D, 8'h8D);
        step_exp(1'b1, 1'b1, 10'd1023, 8'h00, 8'h80);
        step_exp(1'b1, 1'b1, 10'd255, 8'h7F, 8'hFF);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'd0);

        // Accumulator stream stepping by 16, two periods, with a 5-cycle ce gap.
        for (int i = 0; i < 128; i++) begin
            if (i == 70) begin
                for (int j = 0; j < 5; j++) step(1'b0, 1'b1, 10'($urandom));
            end
            step(1'b1, 1'b1, 10'((i * 16) % 1024));
        end

        // Reset with three samples in flight.
        step(1'b1, 1'b1, 10'd100);
        step(1'b1, 1'b1, 10'd300);
        step(1'b1, 1'b1, 10'd700);
        reset = 1'b0;
        #2;
        check("midrst_valid_tc", 32'(amp_valid_tc), 32'd0);
        check("midrst_valid_ob", 32'(amp_valid_ob), 32'd0);
        check("midrst_amp_tc",   32'(amplitude_tc), 32'h00);
        check("midrst_amp_ob",   32'(amplitude_ob), 32'h80);
        exp_tc_q.delete();
        exp_ob_q.delete();
        valid_pipe = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 10'd0);
        step(1'b1, 1'b1, 10'd50);
        step(1'b1, 1'b1, 10'd600);
        step(1'b1, 1'b1, 10'd900);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'd0);

        // Full phase sweep, including the 1023 -> 0 wrap.
        for (int p = 0; p < 1024; p++) step(1'b1, 1'b1, 10'(p));
        step(1'b1, 1'b1, 10'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 10'd0);

        check("sb_empty_tc", 32'(exp_tc_q.size()), 32'd0);
        check("sb_empty_ob", 32'(exp_ob_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
